// File: rtl/gfifo_control.sv
// rtl/gfifo_control.sv - difftest step FIFO toward the host checker with a sticky failure flag.
// Optional macro GFIFO_COALESCE_EN folds steps into a saturating accumulator instead of dropping them.
module gfifo_control #(
  parameter int STEP_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 12
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [STEP_WIDTH-1:0]      step,
  output logic                       host_valid,
  output logic [CNT_W-1:0]           host_step,
  input  logic                       host_ready,
  input  logic                       result_valid,
  input  logic                       result_fail,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       simv_result
);

  localparam int AW = $clog2(DEPTH);

  logic [CNT_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             fail_seen_q, fail_seen_d;
  logic             simv_result_q, simv_result_d;

  logic             empty, full, pop, push, lost, fail_evt;
  logic [CNT_W-1:0] push_data;

`ifdef GFIFO_COALESCE_EN
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W:0]   sum_wide;
  logic [CNT_W-1:0] sum;
`endif

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && host_ready;

  assign host_valid  = !empty;
  assign host_step   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign level       = wr_ptr_q - rd_ptr_q;
  assign overflow    = overflow_q;
  assign simv_result = simv_result_q;
  assign fail_evt    = result_valid && result_fail;

  always_comb begin
    push      = 1'b0;
    lost      = 1'b0;
    push_data = '0;
`ifdef GFIFO_COALESCE_EN
    sum_wide  = {1'b0, acc_q} + (CNT_W+1)'(step);
    sum       = sum_wide[CNT_W] ? '1 : sum_wide[CNT_W-1:0];
    lost      = sum_wide[CNT_W];
    push      = (sum != '0) && (!full || pop);
    push_data = sum;
    acc_d     = push ? '0 : sum;
`else
    push      = (step != '0) && (!full || pop);
    lost      = (step != '0) && full && !pop;
    push_data = CNT_W'(step);
`endif
  end

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d      = rd_ptr_q + (AW+1)'(pop);
    overflow_d    = overflow_q | lost;
    fail_seen_d   = fail_seen_q | fail_evt;
    simv_result_d = simv_result_q | lost | fail_evt;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      overflow_q    <= 1'b0;
      fail_seen_q   <= 1'b0;
      simv_result_q <= 1'b0;
`ifdef GFIFO_COALESCE_EN
      acc_q         <= '0;
`endif
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      overflow_q    <= overflow_d;
      fail_seen_q   <= fail_seen_d;
      simv_result_q <= simv_result_d;
`ifdef GFIFO_COALESCE_EN
      acc_q         <= acc_d;
`endif
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_gfifo_control.sv
// tb/tb_gfifo_control.sv - queue-model bench for gfifo_control, directed scenarios plus random traffic.
module tb_gfifo_control;

  localparam int STEP_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int CNT_W      = 12;
  localparam int LW         = $clog2(DEPTH) + 1;
  localparam int MAXV       = (1 << CNT_W) - 1;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [STEP_WIDTH-1:0] step;
  logic                  host_valid;
  logic [CNT_W-1:0]      host_step;
  logic                  host_ready;
  logic                  result_valid;
  logic                  result_fail;
  logic                  overflow;
  logic [LW-1:0]         level;
  logic                  simv_result;

  gfifo_control #(.STEP_WIDTH(STEP_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .step(step),
    .host_valid(host_valid), .host_step(host_step), .host_ready(host_ready),
    .result_valid(result_valid), .result_fail(result_fail),
    .overflow(overflow), .level(level), .simv_result(simv_result)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  int unsigned mq[$];
  bit          m_ovf;
  bit          m_fail;
  int          m_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: occupancy is just the queue length, head is the front element.
  task automatic model_step(input bit r, input int s, input bit rdy, input bit rv, input bit rf);
    bit full, pop;
    int sum;
    if (!r) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_fail = 1'b0;
      m_acc  = 0;
      return;
    end
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && rdy;
    if (pop) void'(mq.pop_front());
`ifdef GFIFO_COALESCE_EN
    sum = m_acc + s;
    if (sum > MAXV) begin
      sum   = MAXV;
      m_ovf = 1'b1;
    end
    if (sum != 0 && (!full || pop)) begin
      mq.push_back(sum);
      m_acc = 0;
    end else begin
      m_acc = sum;
    end
`else
    sum = s;
    if (sum != 0) begin
      if (!full || pop) mq.push_back(sum);
      else m_ovf = 1'b1;
    end
`endif
    if (rv && rf) m_fail = 1'b1;
  endtask

  task automatic cyc(input bit r, input int s, input bit rdy, input bit rv, input bit rf);
    reset        = r;
    step         = STEP_WIDTH'(s);
    host_ready   = rdy;
    result_valid = rv;
    result_fail  = rf;
    @(posedge clock);
    model_step(r, s, rdy, rv, rf);
    #1;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("host_valid", 32'(host_valid), 32'(mq.size() != 0));
      chk("host_step", 32'(host_step), (mq.size() != 0) ? mq[0] : 32'd0);
      chk("level", 32'(level), 32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("simv_result", 32'(simv_result), 32'(m_fail | m_ovf));
    end
  end

  initial begin
    int s, pct;
    bit r, rdy, rv, rf;

    cyc(0, 0, 0, 0, 0);
    chk_en = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(host_valid), 0);
    chk("rst_step", 32'(host_step), 0);
    chk("rst_simv", 32'(simv_result), 0);

    // single step through with latency one
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 3, 1, 0, 0);
    chk("t1_valid", 32'(host_valid), 1);
    chk("t1_step", 32'(host_step), 3);
    chk("t1_level", 32'(level), 1);
    cyc(1, 0, 1, 0, 0);
    chk("t1_drained", 32'(level), 0);

    // fill to full, then one more step
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, 0, 0);
    chk("full_level", 32'(level), 16);
    chk("full_ovf", 32'(overflow), 0);
    chk("model_full", 32'(mq.size()), 16);
    cyc(1, 1, 0, 0, 0);
`ifdef GFIFO_COALESCE_EN
    chk("acc_ovf", 32'(overflow), 0);
    chk("acc_level", 32'(level), 16);
    chk("model_acc", 32'(m_acc), 1);
`else
    chk("drop_ovf", 32'(overflow), 1);
    chk("drop_simv", 32'(simv_result), 1);
`endif

    // push and pop together while full
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, 0, 0);
    cyc(1, 5, 1, 0, 0);
    chk("pp_level", 32'(level), 16);
    chk("pp_ovf", 32'(overflow), 0);
    for (int i = 0; i < DEPTH - 1; i++) cyc(1, 0, 1, 0, 0);
    chk("pp_last", 32'(host_step), 5);
    chk("pp_last_level", 32'(level), 1);
    cyc(1, 0, 1, 0, 0);
    chk("pp_empty", 32'(host_valid), 0);

    // sticky verdict
    cyc(1, 0, 0, 0, 0);
    chk("v_before", 32'(simv_result), 0);
    cyc(1, 0, 0, 1, 1);
    chk("v_set", 32'(simv_result), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1, 0);
      chk("v_sticky", 32'(simv_result), 1);
    end
    chk("v_no_ovf", 32'(overflow), 0);

    // reset mid-stream discards queue and the concurrent step
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 2, 0, 0, 0);
    chk("mid_level", 32'(level), 7);
    cyc(0, 9, 0, 0, 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_valid", 32'(host_valid), 0);
    chk("mid_rst_simv", 32'(simv_result), 0);
    cyc(1, 0, 0, 0, 0);
    chk("mid_discard", 32'(level), 0);

    // random traffic with varying drain rate; some segments never drain
    for (int seg = 0; seg < 30; seg++) begin
      if (seg % 3 == 0) cyc(0, 0, 0, 0, 0);
      pct = (seg % 4 == 1) ? 0 : int'($urandom_range(0, 100));
      for (int i = 0; i < 100; i++) begin
        r   = ($urandom_range(0, 299) != 0);
        s   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 255));
        rdy = (int'($urandom_range(0, 99)) < pct);
        rv  = ($urandom_range(0, 199) == 0);
        rf  = $urandom_range(0, 1) != 0;
        cyc(r, s, rdy, rv, rf);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
